// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver that assembles four consecutive bytes into one packet on pd0..pd3.
// A framing error discards the partial packet; a long idle gap after a partial packet also discards it.
module uart_rx #(
  parameter int OVS  = 16,
  parameter int TOUT = 160
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       rxck,
  input  logic       rxsd,
  output logic [7:0] pd0,
  output logic [7:0] pd1,
  output logic [7:0] pd2,
  output logic [7:0] pd3,
  output logic       rdone,
  output logic       ferr,
  output logic       busy
);

  localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int IW = $clog2(TOUT + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;

  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    slot_q [4];
  logic [7:0]    slot_d [4];
  logic [1:0]    idx_q, idx_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    pd_q [4];
  logic [7:0]    pd_d [4];
  logic          rdone_q, rdone_d;
  logic          ferr_q, ferr_d;
  logic          rx;

  assign rx    = sync2_q;
  assign pd0   = pd_q[0];
  assign pd1   = pd_q[1];
  assign pd2   = pd_q[2];
  assign pd3   = pd_q[3];
  assign rdone = rdone_q;
  assign ferr  = ferr_q;
  assign busy  = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    idle_d  = idle_q;
    pd_d    = pd_q;
    rdone_d = 1'b0;
    ferr_d  = 1'b0;
    if (rxck) begin
      case (state_q)
        S_IDLE: begin
          if (idx_q != 2'd0) begin
            if (idle_q == IDLE_LAST) begin
              idx_d  = 2'd0;
              idle_d = '0;
            end else begin
              idle_d = idle_q + 1'b1;
            end
          end
          // A start edge coinciding with a timeout still begins a frame; idx_d is 0 then.
          if (!rx) begin
            state_d = S_START;
            tick_d  = '0;
            idle_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == TICK_HALF) begin
            tick_d  = '0;
            bit_d   = 3'd0;
            state_d = rx ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            sh_d   = {rx, sh_q[7:1]};
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rx) begin
              slot_d[idx_q] = sh_q;
              idx_d         = idx_q + 1'b1;
              state_d       = S_IDLE;
              // The fourth byte bypasses its slot so the whole packet lands on one edge.
              if (idx_q == 2'd3) begin
                pd_d[0] = slot_q[0];
                pd_d[1] = slot_q[1];
                pd_d[2] = slot_q[2];
                pd_d[3] = sh_q;
                rdone_d = 1'b1;
              end
            end else begin
              ferr_d  = 1'b1;
              idx_d   = 2'd0;
              state_d = S_BRK;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_BRK: begin
          if (rx) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      idx_q   <= 2'd0;
      idle_q  <= '0;
      rdone_q <= 1'b0;
      ferr_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= 8'h00;
        pd_q[i]   <= 8'h00;
      end
    end else begin
      sync1_q <= rxsd;
      sync2_q <= sync1_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      rdone_q <= rdone_d;
      ferr_q  <= ferr_d;
      for (int i = 0; i < 4; i++) begin
        slot_q[i] <= slot_d[i];
        pd_q[i]   <= pd_d[i];
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of clean packets plus hand-written framing, glitch, timeout,
// reset and back-to-back sequences. rxck fires once every 4 clk; one bit lasts 16 rxck ticks.
module tb_uart_rx;
  localparam int OVS = 16;

  logic       rst, clk, rxck, rxsd;
  logic [7:0] pd0, pd1, pd2, pd3;
  logic       rdone, ferr, busy;

  uart_rx #(.OVS(16), .TOUT(160)) dut (
    .rst(rst), .clk(clk), .rxck(rxck), .rxsd(rxsd),
    .pd0(pd0), .pd1(pd1), .pd2(pd2), .pd3(pd3),
    .rdone(rdone), .ferr(ferr), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] tx;   // byte sent first is in [7:0]
    logic [31:0] exp;  // {pd3, pd2, pd1, pd0}
  } vec_t;

  int errors = 0;
  int checks = 0;
  int rdone_cnt = 0, ferr_cnt = 0, cyc = 0;
  int last_rd = 0, prev_rd = 0;
  logic [31:0] last_pd = '0, prev_pd = '0;
  logic rd_prev = 0, fe_prev = 0, rd_wide = 0, fe_wide = 0;
  int ph = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    rxck = 0;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      rxck = (ph == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    cyc++;
    if (rdone) begin
      rdone_cnt++;
      prev_rd = last_rd;
      last_rd = cyc;
      prev_pd = last_pd;
      last_pd = {pd3, pd2, pd1, pd0};
    end
    if (ferr) ferr_cnt++;
    if (rdone && rd_prev) rd_wide = 1;
    if (ferr && fe_prev) fe_wide = 1;
    rd_prev = rdone;
    fe_prev = ferr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (rxck !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxsd = v;
    wait_ticks(OVS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_pkt(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1);
  endtask

  function automatic logic [31:0] pd_all();
    return {pd3, pd2, pd1, pd0};
  endfunction

  vec_t vecs [3];
  int r0, f0;

  initial begin
    vecs[0] = '{tx: 32'hF00FA355, exp: 32'hF00FA355};
    vecs[1] = '{tx: 32'h0180FF00, exp: 32'h0180FF00};
    vecs[2] = '{tx: 32'hA55AC33C, exp: 32'hA55AC33C};

    rst = 0;
    rxsd = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_pd", pd_all(), 32'h0);
    chk("reset_rdone", {31'b0, rdone}, 32'h0);
    chk("reset_ferr", {31'b0, ferr}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1;
    wait_ticks(4);

    for (int v = 0; v < 3; v++) begin
      r0 = rdone_cnt; f0 = ferr_cnt;
      send_pkt(vecs[v].tx);
      wait_ticks(4);
      chk($sformatf("vec%0d_pd", v), pd_all(), vecs[v].exp);
      chk($sformatf("vec%0d_rdone", v), rdone_cnt - r0, 1);
      chk($sformatf("vec%0d_ferr", v), ferr_cnt - f0, 0);
    end

    // Start-bit glitch: 4 ticks low, rejected at the half-bit check.
    r0 = rdone_cnt; f0 = ferr_cnt;
    rxsd = 0;
    wait_ticks(2);
    chk("glitch_busy_hi", {31'b0, busy}, 32'h1);
    wait_ticks(2);
    rxsd = 1;
    wait_ticks(12);
    chk("glitch_busy_lo", {31'b0, busy}, 32'h0);
    chk("glitch_events", (rdone_cnt - r0) + (ferr_cnt - f0), 0);
    chk("glitch_pd", pd_all(), 32'hA55AC33C);

    // Framing error on the third byte, line held low, then a clean packet.
    r0 = rdone_cnt; f0 = ferr_cnt;
    send_frame(8'hC1, 1'b1);
    send_frame(8'hC2, 1'b1);
    send_frame(8'hC3, 1'b0);
    wait_ticks(3 * OVS);
    chk("brk_busy", {31'b0, busy}, 32'h1);
    rxsd = 1;
    wait_ticks(2 * OVS);
    chk("brk_busy_lo", {31'b0, busy}, 32'h0);
    chk("ferr_count", ferr_cnt - f0, 1);
    chk("ferr_no_rdone", rdone_cnt - r0, 0);
    chk("ferr_pd_kept", pd_all(), 32'hA55AC33C);
    send_pkt(32'h44332211);
    wait_ticks(4);
    chk("ferr_pkt_pd", pd_all(), 32'h44332211);
    chk("ferr_pkt_rdone", rdone_cnt - r0, 1);
    chk("ferr_pkt_ferr", ferr_cnt - f0, 1);

    // Partial packet followed by a gap longer than the timeout.
    r0 = rdone_cnt; f0 = ferr_cnt;
    send_frame(8'hE1, 1'b1);
    send_frame(8'hE2, 1'b1);
    rxsd = 1;
    wait_ticks(161);
    send_pkt(32'h04030201);
    wait_ticks(4);
    chk("tout_pd", pd_all(), 32'h04030201);
    chk("tout_rdone", rdone_cnt - r0, 1);
    chk("tout_ferr", ferr_cnt - f0, 0);

    // A gap shorter than the timeout keeps the partial packet.
    r0 = rdone_cnt;
    send_frame(8'h61, 1'b1);
    send_frame(8'h62, 1'b1);
    wait_ticks(100);
    send_frame(8'h63, 1'b1);
    send_frame(8'h64, 1'b1);
    wait_ticks(4);
    chk("short_gap_pd", pd_all(), 32'h64636261);
    chk("short_gap_rdone", rdone_cnt - r0, 1);

    // Reset during bit 4 of the third byte.
    r0 = rdone_cnt; f0 = ferr_cnt;
    send_frame(8'h81, 1'b1);
    send_frame(8'h82, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rxsd = 1;
    wait_ticks(OVS / 2);
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_pd", pd_all(), 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_pulses", {30'b0, rdone, ferr}, 32'h0);
    rst = 1;
    rxsd = 1;
    wait_ticks(2 * OVS);
    chk("rst_mid_events", (rdone_cnt - r0) + (ferr_cnt - f0), 0);
    send_pkt(32'h74737271);
    wait_ticks(4);
    chk("rst_after_pd", pd_all(), 32'h74737271);
    chk("rst_after_rdone", rdone_cnt - r0, 1);

    // Two packets with no inter-frame gap.
    r0 = rdone_cnt;
    send_pkt(32'hADACABAA);
    send_pkt(32'hBDBCBBBA);
    wait_ticks(4);
    chk("b2b_rdone", rdone_cnt - r0, 2);
    chk("b2b_first_pd", prev_pd, 32'hADACABAA);
    chk("b2b_second_pd", pd_all(), 32'hBDBCBBBA);
    chk("b2b_spacing", last_rd - prev_rd, 40 * OVS * 4);

    chk("rdone_one_cycle", {31'b0, rd_wide}, 32'h0);
    chk("ferr_one_cycle", {31'b0, fe_wide}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
